stoch_decode: RTL and testbench
===============================

# stoch_decode

Stochastic-to-binary decoder: counts the ones in a single unipolar stochastic bitstream over a fixed window of 2^W qualified samples and presents the result as a W-bit binary word with a one-cycle valid strobe. Sits at the output of the stochastic datapath, after the cascaded AND multiply and other gate-level stream stages, and converts network outputs back to binary for readout and training logic.

## Interface
- W, 8: result width; window length is 2^W qualified samples (W >= 2)
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset
- IN  in  1  stochastic bitstream sample
- EN  in  1  sample qualifier; IN is counted only on cycles with EN=1
- START  in  1  begin a window; accepted in IDLE or DONE only
- OUT  out  W  decoded value, held until the next result
- OUT_VALID  out  1  one-cycle strobe, OUT updated this cycle
- BUSY  out  1  high while in COUNT

## Operation
- States: IDLE, COUNT, DONE. Reset forces IDLE, OUT=0, OUT_VALID=0, BUSY=0, and clears both counters.
- IDLE: START=1 -> COUNT; sample counter and ones accumulator cleared.
- COUNT: on each cycle with EN=1, increment the W-bit sample counter and add IN to the (W+1)-bit ones accumulator. EN=0 cycles change nothing. START is ignored.
- End of window: on the EN=1 cycle where the sample counter equals 2^W-1, that cycle's IN is included, and the state moves to DONE.
- DONE (exactly one cycle): OUT = min(acc, 2^W-1), saturating so an all-ones stream reads 2^W-1; OUT_VALID=1. START=1 in DONE -> COUNT with cleared counters, otherwise -> IDLE.
- BUSY = (state == COUNT).
- Reset mid-window discards the partial count. OUT returns to 0.

## Timing
- With EN held high and START at cycle t: samples are taken at t+1 .. t+2^W, and OUT/OUT_VALID are asserted at t+2^W+1.
- With EN gaps, latency stretches by the number of EN=0 cycles in COUNT.
- OUT is registered, changes only in the OUT_VALID cycle, and holds otherwise.
- IN/EN in IDLE and DONE cycles are never sampled. This applies only when STOCH_DECODE_CONTINUOUS_EN is undefined.

## Configuration
- STOCH_DECODE_CONTINUOUS_EN defined:
  - After the first START, the block never returns to IDLE. Only reset does that.
  - At end of window, OUT and OUT_VALID update on the next cycle while the state stays COUNT.
  - Counters restart so the sample on the OUT_VALID cycle, if EN=1, is the first sample of the next window. There are no bubbles.
  - OUT_VALID pulses every 2^W qualified samples. BUSY stays 1.
- Undefined: single-shot IDLE/COUNT/DONE behaviour as above.

## Test plan
- W=8, reset, START, IN=1 and EN=1 for 256 cycles -> OUT_VALID exactly at START+257, OUT=255 (saturated). Then IDLE, BUSY=0.
- W=8, IN alternating 1,0 with EN=1 -> OUT=128. With IN=0 throughout -> OUT=0, OUT_VALID single pulse.
- W=4, EN toggling 1,0 with IN=1 only on EN=0 cycles -> OUT=0, OUT_VALID at START+33.
- W=4, START pulsed mid-COUNT -> ignored, result at the original cycle. START in DONE -> new window begins with no IDLE cycle.
- W=4, RST_N low at sample 7 -> OUT=0, OUT_VALID=0, IDLE. Subsequent window with IN=1 for 12 of 16 samples -> OUT=12.
- STOCH_DECODE_CONTINUOUS_EN, W=4, IN pattern 1110 repeated, EN=1 -> OUT_VALID every 16 cycles, each OUT=12, BUSY constant 1, no dropped samples.

Source files
------------

// File: rtl/stoch_decode.sv
// rtl/stoch_decode.sv - stochastic bitstream to binary decoder over a 2^W sample window
//
// Purpose: counts the ones in a unipolar stochastic bitstream over 2^W
// qualified (en_i=1) samples and presents the count as a W-bit word.
// The result saturates at 2^W-1, so an all-ones stream reads full scale.
//
// Build option: STOCH_DECODE_CONTINUOUS_EN
//   undefined: single-shot IDLE -> COUNT -> DONE operation.
//   defined:   free-running back-to-back windows once started.
//              Only reset returns the block to IDLE.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset
//   in_i         stochastic bitstream sample
//   en_i         sample qualifier; in_i is counted only when en_i=1
//   start_i      begin a window; accepted in IDLE or DONE
//   out_o        decoded value, held until the next result
//   out_valid_o  one-cycle strobe, out_o updated this cycle
//   busy_o       high while counting
module stoch_decode #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_i,
  input  logic         en_i,
  input  logic         start_i,
  output logic [W-1:0] out_o,
  output logic         out_valid_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   cnt_q;
  logic [W:0]     acc_q;
  logic [W-1:0]   out_q;
  logic           out_valid_q;

  logic [W:0]     acc_d;
  logic [W-1:0]   sat_d;
  logic           last_d;

  // acc_d includes the current sample so the final sample of a window
  // lands in the result on the same edge that closes the window.
  always_comb begin
    acc_d  = acc_q + {{W{1'b0}}, in_i};
    sat_d  = acc_d[W] ? {W{1'b1}} : acc_d[W-1:0];
    last_d = en_i && (cnt_q == {W{1'b1}});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COUNT;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        COUNT: begin
          if (en_i) begin
            if (last_d) begin
              out_q       <= sat_d;
              out_valid_q <= 1'b1;
              // Clearing here means the very next qualified sample starts
              // a fresh window (no bubble in continuous mode).
              cnt_q       <= '0;
              acc_q       <= '0;
`ifndef STOCH_DECODE_CONTINUOUS_EN
              state_q     <= DONE;
`endif
            end else begin
              cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
              acc_q <= acc_d;
            end
          end
        end
        DONE: begin
          if (start_i) begin
            state_q <= COUNT;
            cnt_q   <= '0;
            acc_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q == COUNT);

endmodule

// File: tb/tb_stoch_decode.sv
// tb/tb_stoch_decode.sv - directed self-checking bench for stoch_decode
module tb_stoch_decode;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       en;
  logic       start8;
  logic       start4;
  logic [7:0] out8;
  logic       v8;
  logic       b8;
  logic [3:0] out4;
  logic       v4;
  logic       b4;

  int vecs;
  int errs;
  int n;
  logic bf;

  stoch_decode #(.W(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .in_i(din), .en_i(en), .start_i(start8),
    .out_o(out8), .out_valid_o(v8), .busy_o(b8)
  );

  stoch_decode #(.W(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .in_i(din), .en_i(en), .start_i(start4),
    .out_o(out4), .out_valid_o(v4), .busy_o(b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs for COUNT cycle k (k=1 is the first cycle after START).
  task automatic drive(input int mode, input int k);
    start4 = 1'b0;
    case (mode)
      0: begin en = 1'b1; din = 1'b1; end
      1: begin en = 1'b1; din = k[0]; end
      2: begin en = 1'b1; din = 1'b0; end
      3: begin en = ~k[0]; din = k[0]; end
      4: begin en = 1'b1; din = 1'b1; start4 = (k == 5); end
      5: begin en = 1'b1; din = (k <= 12); end
      default: begin en = 1'b0; din = 1'b0; end
    endcase
  endtask

  // START is raised in the current cycle (cycle 0); k returns the cycle
  // offset at which out_valid is seen, bounded at 2000 cycles.
  task automatic run_window(input bit sel4, input int mode, output int k, output logic busy_first);
    if (sel4) start4 = 1'b1; else start8 = 1'b1;
    en  = 1'b0;
    din = 1'b0;
    step();
    start4 = 1'b0;
    start8 = 1'b0;
    busy_first = sel4 ? b4 : b8;
    k = 1;
    while (k < 2000) begin
      drive(mode, k);
      step();
      k++;
      if (sel4 ? v4 : v8) break;
    end
    start4 = 1'b0;
    en     = 1'b0;
    din    = 1'b0;
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    rst_n  = 1'b0;
    din    = 1'b0;
    en     = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out8", out8, 0);
    chk("rst_v8", v8, 0);
    chk("rst_b8", b8, 0);
    chk("rst_out4", out4, 0);
    chk("rst_v4", v4, 0);
    chk("rst_b4", b4, 0);

`ifndef STOCH_DECODE_CONTINUOUS_EN
    // W=8 all ones: saturated full scale, strobe at START+257.
    run_window(1'b0, 0, n, bf);
    chk("ones8_busy", bf, 1);
    chk("ones8_lat", n, 257);
    chk("ones8_out", out8, 255);
    step();
    chk("ones8_pulse", v8, 0);
    chk("ones8_idle", b8, 0);
    chk("ones8_hold", out8, 255);

    // W=8 alternating 1,0.
    run_window(1'b0, 1, n, bf);
    chk("alt8_lat", n, 257);
    chk("alt8_out", out8, 128);

    // W=8 all zeros, single pulse.
    run_window(1'b0, 2, n, bf);
    chk("zero8_lat", n, 257);
    chk("zero8_out", out8, 0);
    step();
    chk("zero8_pulse", v8, 0);

    // W=4 EN toggling, ones only on EN=0 cycles.
    run_window(1'b1, 3, n, bf);
    chk("gap4_lat", n, 33);
    chk("gap4_out", out4, 0);

    // W=4 START mid-COUNT ignored.
    run_window(1'b1, 4, n, bf);
    chk("midstart4_lat", n, 17);
    chk("midstart4_out", out4, 15);
    // START in the DONE cycle: straight back to COUNT.
    run_window(1'b1, 5, n, bf);
    chk("donestart4_busy", bf, 1);
    chk("donestart4_lat", n, 17);
    chk("donestart4_out", out4, 12);
    step();
    chk("donestart4_idle", b4, 0);

    // W=4 reset at sample 7 discards the window.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    en     = 1'b1;
    din    = 1'b1;
    repeat (6) step();
    chk("midrst4_busy", b4, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    en    = 1'b0;
    din   = 1'b0;
    chk("midrst4_out", out4, 0);
    chk("midrst4_v", v4, 0);
    chk("midrst4_b", b4, 0);
    step();
    chk("midrst4_stay_idle", b4, 0);
    run_window(1'b1, 5, n, bf);
    chk("after_rst4_lat", n, 17);
    chk("after_rst4_out", out4, 12);
`else
    begin
      int pulses;
      int exp_cyc;
      pulses  = 0;
      exp_cyc = 17;
      start4  = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        en  = 1'b1;
        din = (((k - 1) % 4) != 3);
        step();
        chk("cont_busy", b4, 1);
        if (v4) begin
          pulses++;
          chk("cont_cycle", k + 1, exp_cyc);
          chk("cont_out", out4, 12);
          exp_cyc += 16;
        end
      end
      chk("cont_pulses", pulses, 3);
      en  = 1'b0;
      din = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
